strhw_lps_server: RTL
=====================

// Module: strhw_lps_server
// PURPOSE
//  Responder for the transformation requests issued by the g_N compression stage.
//  - Accepts one 512-bit operand plus an opcode and computes SL, P, LPS or passthrough.
//  - Returns the 512-bit result over a valid/ready response channel.
//  - The L layer is time-multiplexed over 64-bit lanes to trade latency for area.
//  - Sits between the g_N/E-round sequencer and the shared S/P/L datapath.
// PARAMETERS
//  LANES  1  64-bit L lanes computed per cycle; legal values 1,2,4,8; L phase takes 8/LANES cycles
// PORTS
//  clk_i         in   1    clock
//  rst_i         in   1    reset, asynchronous, active-high
//  req_valid_i   in   1    request valid
//  req_ready_o   out  1    server can accept a request
//  req_op_i      in   2    opcode: 00 SL, 01 P, 10 LPS, 11 reserved
//  req_a_i       in   512  operand (uint512); word j = bits [64j+63:64j], byte k = [8k+7:8k]
//  rsp_valid_o   out  1    result valid
//  rsp_ready_i   in   1    consumer accepts result
//  rsp_result_o  out  512  result (uint512)
//  busy_o        out  1    high in any state other than IDLE
// BEHAVIOUR
//  Reset values: req_ready_o=1, rsp_valid_o=0, rsp_result_o=0, busy_o=0, FSM=IDLE, lane counter=0.
//  Request handshake: accept when req_valid_i && req_ready_o; req_ready_o is high only in IDLE.
//  Capture: opcode and operand are captured at accept; later changes on req_* are ignored.
//  FSM: IDLE -> SUB (1 cycle) -> LIN (8/LANES cycles, SL/LPS only) -> DONE -> IDLE.
//  SUB stage:
//   - S: every byte b -> PI[b].
//   - P: byte transposition, out byte[8i+j] = in byte[8j+i].
//   - LPS applies S then P combinationally; the result is registered into the work register.
//   - P and reserved opcodes go from SUB straight to DONE; reserved returns the operand unchanged.
//  LIN stage:
//   - Each cycle, lanes c*LANES .. c*LANES+LANES-1 are replaced by l64(word).
//   - l64(w) = XOR of A[63-i] over every set bit i of w (bit 63 selects A[0]).
//   - Lane counter increments by LANES and wraps to 0 on leaving LIN.
//  Latency from the accept cycle T:
//   - P and reserved: rsp_valid_o rises at T+2.
//   - SL and LPS: rsp_valid_o rises at T+2+8/LANES.
//  DONE: rsp_valid_o=1 and rsp_result_o holds stable until rsp_valid_o && rsp_ready_i.
//   - The cycle after the response handshake: IDLE, req_ready_o=1.
//   - Back-to-back throughput is therefore one operation per latency+1 cycles.
//  Backpressure: rsp_ready_i low in DONE holds the state indefinitely; no new request is accepted.
//  rsp_ready_i outside DONE is ignored.
//  Reset mid-operation: the in-flight operation is abandoned; no response is produced.
//  All arithmetic is pure XOR/bit selection; no carries, no width growth.
// STRUCTURE
//  strhw_common_types additions:
//   - lps_op_t enum {OP_SL, OP_P, OP_LPS, OP_RSVD}.
//   - lps_state_t {IDLE, SUB, LIN, DONE}.
//   - PI[256] byte S-box constant.
//   - A[64] 64-bit L-matrix constant.
//   - uint64 typedef.
//  Sub-module strhw_l64: combinational 64-bit L transform (uint64 in -> uint64 out).
//   - Instantiated LANES times, lanes selected by the counter.
//  S and P stay inline as generate loops; the FSM, work register and counter live in this module.
// TESTING
//  1. Reset with req_valid_i=1 held -> req_ready_o=1, rsp_valid_o=0, rsp_result_o=0.
//  2. OP_P, operand byte k = k (k=0..63) -> result byte 1 = 0x08, byte 8 = 0x01, byte 63 = 0x3F.
//     rsp_valid_o at T+2.
//  3. OP_SL, operand 0 -> 8 words each equal l64(64'hFCFCFCFCFCFCFCFC) per the package model.
//     rsp_valid_o at T+10 (LANES=1) and at T+3 (LANES=8).
//  4. OP_LPS, operand word0 = 64'h1, rest 0:
//     - Result equals the golden software LPS.
//     - Also compare against OP_SL applied to the OP_P output.
//  5. Hold rsp_ready_i=0 for 5 cycles in DONE -> result stable, req_ready_o=0.
//     - A second req_valid_i is not accepted until the cycle after rsp_ready_i=1.
//  6. Assert rst_i during LIN -> FSM returns to IDLE, no rsp_valid_o pulse.
//     - A following OP_P completes correctly.
//     - OP_RSVD returns the operand unchanged.

Source files
------------

// File: rtl/strhw_lps_server_pkg.sv
// Shared types and constants for the LPS transformation server:
// opcode/state enums, the PI byte substitution table and the L-layer matrix.
package strhw_lps_server_pkg;

   typedef logic [63:0] uint64;

   typedef enum logic [1:0] {
      OP_SL   = 2'b00,
      OP_P    = 2'b01,
      OP_LPS  = 2'b10,
      OP_RSVD = 2'b11
   } lps_op_t;

   typedef enum logic [1:0] {
      IDLE = 2'b00,
      SUB  = 2'b01,
      LIN  = 2'b10,
      DONE = 2'b11
   } lps_state_t;

   localparam logic [7:0] PI [256] = '{
      8'd252, 8'd238, 8'd221, 8'd17,  8'd207, 8'd110, 8'd49,  8'd22,  8'd251, 8'd196, 8'd250, 8'd218, 8'd35,  8'd197, 8'd4,   8'd77,
      8'd233, 8'd119, 8'd240, 8'd219, 8'd147, 8'd46,  8'd153, 8'd186, 8'd23,  8'd54,  8'd241, 8'd187, 8'd20,  8'd205, 8'd95,  8'd193,
      8'd249, 8'd24,  8'd101, 8'd90,  8'd226, 8'd92,  8'd239, 8'd33,  8'd129, 8'd28,  8'd60,  8'd66,  8'd139, 8'd1,   8'd142, 8'd79,
      8'd5,   8'd132, 8'd2,   8'd174, 8'd227, 8'd106, 8'd143, 8'd160, 8'd6,   8'd11,  8'd237, 8'd152, 8'd127, 8'd212, 8'd211, 8'd31,
      8'd235, 8'd52,  8'd44,  8'd81,  8'd234, 8'd200, 8'd72,  8'd171, 8'd242, 8'd42,  8'd104, 8'd162, 8'd253, 8'd58,  8'd206, 8'd204,
      8'd181, 8'd112, 8'd14,  8'd86,  8'd8,   8'd12,  8'd118, 8'd18,  8'd191, 8'd114, 8'd19,  8'd71,  8'd156, 8'd183, 8'd93,  8'd135,
      8'd21,  8'd161, 8'd150, 8'd41,  8'd16,  8'd123, 8'd154, 8'd199, 8'd243, 8'd145, 8'd120, 8'd111, 8'd157, 8'd158, 8'd178, 8'd177,
      8'd50,  8'd117, 8'd25,  8'd61,  8'd255, 8'd53,  8'd138, 8'd126, 8'd109, 8'd84,  8'd198, 8'd128, 8'd195, 8'd189, 8'd13,  8'd87,
      8'd223, 8'd245, 8'd36,  8'd169, 8'd62,  8'd168, 8'd67,  8'd201, 8'd215, 8'd121, 8'd214, 8'd246, 8'd124, 8'd34,  8'd185, 8'd3,
      8'd224, 8'd15,  8'd236, 8'd222, 8'd122, 8'd148, 8'd176, 8'd188, 8'd220, 8'd232, 8'd40,  8'd80,  8'd78,  8'd51,  8'd10,  8'd74,
      8'd167, 8'd151, 8'd96,  8'd115, 8'd30,  8'd0,   8'd98,  8'd68,  8'd26,  8'd184, 8'd56,  8'd130, 8'd100, 8'd159, 8'd38,  8'd65,
      8'd173, 8'd69,  8'd70,  8'd146, 8'd39,  8'd94,  8'd85,  8'd47,  8'd140, 8'd163, 8'd165, 8'd125, 8'd105, 8'd213, 8'd149, 8'd59,
      8'd7,   8'd88,  8'd179, 8'd64,  8'd134, 8'd172, 8'd29,  8'd247, 8'd48,  8'd55,  8'd107, 8'd228, 8'd136, 8'd217, 8'd231, 8'd137,
      8'd225, 8'd27,  8'd131, 8'd73,  8'd76,  8'd63,  8'd248, 8'd254, 8'd141, 8'd83,  8'd170, 8'd144, 8'd202, 8'd216, 8'd133, 8'd97,
      8'd32,  8'd113, 8'd103, 8'd164, 8'd45,  8'd43,  8'd9,   8'd91,  8'd203, 8'd155, 8'd37,  8'd208, 8'd190, 8'd229, 8'd108, 8'd82,
      8'd89,  8'd166, 8'd116, 8'd210, 8'd230, 8'd244, 8'd180, 8'd192, 8'd209, 8'd102, 8'd175, 8'd194, 8'd57,  8'd75,  8'd99,  8'd182
   };

   // Row 0 is selected by bit 63 of the L input word.
   localparam uint64 A [64] = '{
      64'h8e20faa72ba0b470, 64'h47107ddd9b505a38, 64'had08b0e0c3282d1c, 64'hd8045870ef14980e,
      64'h6c022c38f90a4c07, 64'h3601161cf205268d, 64'h1b8e0b0e798c13c8, 64'h83478b07b2468764,
      64'ha011d380818e8f40, 64'h5086e740ce47c920, 64'h2843fd2067adea10, 64'h14aff010bdd87508,
      64'h0ad97808d06cb404, 64'h05e23c0468365a02, 64'h8c711e02341b2d01, 64'h46b60f011a83988e,
      64'h90dab52a387ae76f, 64'h486dd4151c3dfdb9, 64'h24b86a840e90f0d2, 64'h125c354207487869,
      64'h092e94218d243cba, 64'h8a174a9ec8121e5d, 64'h4585254f64090fa0, 64'haccc9ca9328a8950,
      64'h9d4df05d5f661451, 64'hc0a878a0a1330aa6, 64'h60543c50de970553, 64'h302a1e286fc58ca7,
      64'h18150f14b9ec46dd, 64'h0c84890ad27623e0, 64'h0642ca05693b9f70, 64'h0321658cba93c138,
      64'h86275df09ce8aaa8, 64'h439da0784e745554, 64'hafc0503c273aa42a, 64'hd960281e9d1d5215,
      64'he230140fc0802984, 64'h71180a8960409a42, 64'hb60c05ca30204d21, 64'h5b068c651810a89e,
      64'h456c34887a3805b9, 64'hac361a443d1c8cd2, 64'h561b0d22900e4669, 64'h2b838811480723ba,
      64'h9bcf4486248d9f5d, 64'hc3e9224312c8c1a0, 64'heffa11af0964ee50, 64'hf97d86d98a327728,
      64'he4fa2054a80b329c, 64'h727d102a548b194e, 64'h39b008152acb8227, 64'h9258048415eb419d,
      64'h492c024284fbaec0, 64'haa16012142f35760, 64'h550b8e9e21f7a530, 64'ha48b474f9ef5dc18,
      64'h70a6a56e2440598e, 64'h3853dc371220a247, 64'h1ca76e95091051ad, 64'h0edd37c48a08a6d8,
      64'h07e095624504536c, 64'h8d70c431ac02a736, 64'hc83862965601dd1b, 64'h641c314b2b8ee083
   };

   function automatic logic [7:0] pi_sub(input logic [7:0] b);
      return PI[b];
   endfunction

endpackage

// File: rtl/strhw_l64.sv
// Combinational 64-bit L transform: XOR of matrix rows selected by the set
// bits of the input word, MSB first.
module strhw_l64
   import strhw_lps_server_pkg::*;
(
   input  uint64 data,
   output uint64 result
);

   uint64 acc_s;

   // Masked XOR accumulation of the selected matrix rows
   always_comb begin
      acc_s = 64'd0;
      for (int i = 0; i < 64; i++) begin
         acc_s = acc_s ^ (A[63-i] & {64{data[i]}});
      end
   end

   assign result = acc_s;

endmodule

// File: rtl/strhw_lps_server.sv
// LPS transformation server: S/P in one SUB cycle, then the L layer
// time-multiplexed over LANES 64-bit lanes per cycle.
module strhw_lps_server
   import strhw_lps_server_pkg::*;
#(
   parameter int LANES = 1
)
(
   input  logic         clk_i,
   input  logic         rst_i,
   input  logic         req_valid_i,
   output logic         req_ready_o,
   input  logic [1:0]   req_op_i,
   input  logic [511:0] req_a_i,
   output logic         rsp_valid_o,
   input  logic         rsp_ready_i,
   output logic [511:0] rsp_result_o,
   output logic         busy_o
);

   localparam logic [3:0] LANE_STEP = 4'(LANES);
   localparam logic [3:0] LANE_LAST = 4'(8 - LANES);

   lps_state_t   state_r, state_s;
   lps_op_t      op_r;
   logic [511:0] work_r, work_s;
   logic [511:0] s_s, p_in_s, p_s, sub_s;
   logic [3:0]   lane_r;
   logic         ready_r, valid_r, busy_r;
   logic         accept_s;
   logic [2:0]   lane_idx_s [LANES];
   uint64        l_in_s     [LANES];
   uint64        l_out_s    [LANES];

   assign accept_s = req_valid_i && ready_r;

   for (genvar k = 0; k < 64; k++) begin : g_sbox
      assign s_s[8*k +: 8] = pi_sub(work_r[8*k +: 8]);
   end

   // LPS feeds the transposition from the S-box output; P transposes the raw operand.
   assign p_in_s = (op_r == OP_LPS) ? s_s : work_r;

   for (genvar i = 0; i < 8; i++) begin : g_prow
      for (genvar j = 0; j < 8; j++) begin : g_pcol
         assign p_s[8*(8*i+j) +: 8] = p_in_s[8*(8*j+i) +: 8];
      end
   end

   for (genvar g = 0; g < LANES; g++) begin : g_lane
      assign lane_idx_s[g] = lane_r[2:0] + 3'(g);
      assign l_in_s[g]     = work_r[{lane_idx_s[g], 6'd0} +: 64];
      strhw_l64 u_l64 (
         .data   (l_in_s[g]),
         .result (l_out_s[g])
      );
   end

   // SUB-stage result selection by opcode
   always_comb begin
      sub_s = work_r;
      case (op_r)
         OP_SL:         sub_s = s_s;
         OP_P, OP_LPS:  sub_s = p_s;
         default:       sub_s = work_r;
      endcase
   end

   // Next-state logic
   always_comb begin
      state_s = state_r;
      case (state_r)
         IDLE: begin
            if (req_valid_i) state_s = SUB;
            else             state_s = IDLE;
         end
         SUB: begin
            if (op_r == OP_SL || op_r == OP_LPS) state_s = LIN;
            else                                 state_s = DONE;
         end
         LIN: begin
            if (lane_r == LANE_LAST) state_s = DONE;
            else                     state_s = LIN;
         end
         DONE: begin
            if (rsp_ready_i) state_s = IDLE;
            else             state_s = DONE;
         end
         default: state_s = IDLE;
      endcase
   end

   // Work register next value: capture, substitute/transpose, or L on the active lanes
   always_comb begin
      work_s = work_r;
      case (state_r)
         IDLE: begin
            if (accept_s) work_s = req_a_i;
            else          work_s = work_r;
         end
         SUB: work_s = sub_s;
         LIN: begin
            for (int g = 0; g < LANES; g++) begin
               work_s[{lane_idx_s[g], 6'd0} +: 64] = l_out_s[g];
            end
         end
         DONE:    work_s = work_r;
         default: work_s = work_r;
      endcase
   end

   // State, datapath and registered handshake flags
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_r <= IDLE;
         op_r    <= OP_SL;
         work_r  <= 512'd0;
         lane_r  <= 4'd0;
         ready_r <= 1'b1;
         valid_r <= 1'b0;
         busy_r  <= 1'b0;
      end else begin
         state_r <= state_s;
         work_r  <= work_s;
         if (accept_s) op_r <= lps_op_t'(req_op_i);
         if (state_r == LIN && lane_r != LANE_LAST) lane_r <= lane_r + LANE_STEP;
         else                                       lane_r <= 4'd0;
         ready_r <= (state_s == IDLE);
         valid_r <= (state_s == DONE);
         busy_r  <= (state_s != IDLE);
      end
   end

   assign req_ready_o  = ready_r;
   assign rsp_valid_o  = valid_r;
   assign rsp_result_o = work_r;
   assign busy_o       = busy_r;

endmodule
